// File: rtl/cpu_sram_arbiter_pkg.sv
// Shared encodings and request-bus layout for the IF/MEM SRAM-like port arbiter.
// No logic here: requester IDs, size codes and the 71-bit request bundle.
package cpu_sram_arbiter_pkg;

    localparam logic REQ_INST = 1'b0;
    localparam logic REQ_DATA = 1'b1;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    localparam int REQ_BUS_W = 1 + 2 + 32 + 4 + 32;

    typedef struct packed {
        logic        wr;
        size_e       size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } req_bus_t;

endpackage

// File: rtl/cpu_sram_arbiter_id_fifo.sv
// Requester-ID FIFO: remembers which side owns each accepted, unanswered transaction.
// Latency: head visible combinationally; push/pop take effect at the next clk edge.
// Backpressure: push ignored when full, pop ignored when empty; push+pop together keeps count.
module req_id_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop_rdy,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_push  = push_vld & ~full;
    assign do_pop   = pop_rdy & ~empty;
    assign head_dat = mem[rd_ptr];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cpu_sram_arbiter.sv
// Arbitrates IF and MEM requesters onto one SRAM-like port and routes in-order responses back.
// Latency: zero added cycles; grant, addr_ok and data_ok routing are purely combinational.
// Backpressure: grant held until mem_addr_ok; mem_req withheld while DEPTH transactions are outstanding.
module cpu_sram_arbiter
    import cpu_sram_arbiter_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        protocol_err
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic                   locked;
    logic                   owner;
    logic [SW-1:0]          starve_cnt;
    logic                   gnt_vld;
    logic                   gnt_id;
    logic                   gnt_req;
    logic                   accept;
    logic                   pop;
    logic                   head_id;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    req_bus_t               inst_bus;
    req_bus_t               data_bus;
    logic [REQ_BUS_W-1:0]   mem_bus;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = REQ_DATA;
        if (locked) begin
            gnt_vld = 1'b1;
            gnt_id  = owner;
        end else if (starve_cnt == STARVE_MAX && inst_req) begin
            gnt_vld = 1'b1;
            gnt_id  = REQ_INST;
        end else if (data_req) begin
            gnt_vld = 1'b1;
            gnt_id  = REQ_DATA;
        end else if (inst_req) begin
            gnt_vld = 1'b1;
            gnt_id  = REQ_INST;
        end
    end

    assign inst_bus = '{wr: inst_wr, size: size_e'(inst_size), addr: inst_addr,
                        wstrb: inst_wstrb, wdata: inst_wdata};
    assign data_bus = '{wr: data_wr, size: size_e'(data_size), addr: data_addr,
                        wstrb: data_wstrb, wdata: data_wdata};
    assign mem_bus  = (gnt_id == REQ_INST) ? inst_bus : data_bus;
    assign {mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata} = mem_bus;

    // resetn gating keeps the slave port quiet for the whole reset cycle, not just after it.
    assign gnt_req      = gnt_vld & ((gnt_id == REQ_DATA) ? data_req : inst_req);
    assign mem_req      = resetn & gnt_req & ~fifo_full;
    assign accept       = mem_req & mem_addr_ok;
    assign inst_addr_ok = accept & (gnt_id == REQ_INST);
    assign data_addr_ok = accept & (gnt_id == REQ_DATA);

    assign pop          = resetn & mem_data_ok & ~fifo_empty;
    assign inst_data_ok = pop & (head_id == REQ_INST);
    assign data_data_ok = pop & (head_id == REQ_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    req_id_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (1)
    ) u_id_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push_vld (accept),
        .push_dat (gnt_id),
        .pop_rdy  (pop),
        .head_dat (head_id),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            locked       <= 1'b0;
            owner        <= REQ_INST;
            starve_cnt   <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (accept) begin
                locked <= 1'b0;
            end else if (mem_req) begin
                locked <= 1'b1;
                owner  <= gnt_id;
            end
            if (mem_data_ok && fifo_count == '0) begin
                protocol_err <= 1'b1;
            end
            if (!inst_req || inst_addr_ok) begin
                starve_cnt <= '0;
            end else if (data_addr_ok && starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule
